// File: rtl/mvm_param.sv
// Parametrised KxK matrix-vector multiply with P MAC lanes, saturation/wrap, optional ReLU.
// Latency: done K*K/P+1 cycles after start, then K result words on consecutive cycles.
// No backpressure: strobes outside IDLE are ignored; results stream out unconditionally.
module mvm_param #(
  parameter int K   = 8,
  parameter int B   = 8,
  parameter int P   = 1,
  parameter bit SAT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loadMatrix,
  input  logic                  loadVector,
  input  logic                  start,
  input  logic                  relu_en,
  input  logic signed [B-1:0]   data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  output logic signed [2*B-1:0] data_out,
  output logic                  ovf
);

  localparam int AW = 2*B + $clog2(K);   // accumulator width, headroom for K products
  localparam int LW = $clog2(K*K);
  localparam int CW = $clog2(K);
  localparam int GN = K / P;             // number of row groups
  localparam int GW = (GN > 1) ? $clog2(GN) : 1;
  localparam int DW = $clog2(K+1);       // drain counter must reach K

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_M  = 3'd1;
  localparam logic [2:0] S_LOAD_V  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  localparam logic signed [AW-1:0] SMAX = {{(AW-2*B+1){1'b0}}, {(2*B-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-2*B+1){1'b1}}, {(2*B-1){1'b0}}};

  logic [2:0]     state;
  logic [LW-1:0]  ld_cnt;
  logic [CW-1:0]  col;
  logic [GW-1:0]  grp;
  logic [DW-1:0]  drn_cnt;
  logic           relu_q;

  logic signed [B-1:0]   mat [K*K];
  logic signed [B-1:0]   vec [K];
  logic signed [AW-1:0]  res [K];
  logic signed [AW-1:0]  acc [P];
  logic signed [AW-1:0]  acc_nxt [P];
  logic signed [2*B-1:0] prod [P];
  logic [CW-1:0]         row_idx [P];

  logic [CW-1:0]         drn_idx;
  logic signed [AW-1:0]  pp_sum;
  logic signed [AW-1:0]  wrap_ext;
  logic signed [2*B-1:0] pp_val;
  logic                  pp_ovf;

  assign busy = (state != S_IDLE);

  // Lane datapath: each lane owns one row of the current group; column 0 restarts the sum
  always_comb begin
    for (int l = 0; l < P; l++) begin
      row_idx[l] = CW'(int'(grp) * P + l);
      prod[l]    = mat[LW'((int'(grp) * P + l) * K + int'(col))] * vec[col];
      acc_nxt[l] = ((col == '0) ? AW'(0) : acc[l]) + AW'(prod[l]);
    end
  end

  // Post-processing of the element being drained: ReLU first, then saturate or wrap
  always_comb begin
    drn_idx  = (drn_cnt < DW'(K)) ? drn_cnt[CW-1:0] : '0;
    pp_sum   = res[drn_idx];
    if (relu_q && pp_sum[AW-1]) begin
      pp_sum = '0;
    end
    wrap_ext = {{(AW-2*B){pp_sum[2*B-1]}}, pp_sum[2*B-1:0]};
    pp_val   = pp_sum[2*B-1:0];
    pp_ovf   = 1'b0;
    if (SAT) begin
      if (pp_sum > SMAX) begin
        pp_val = SMAX[2*B-1:0];
        pp_ovf = 1'b1;
      end else if (pp_sum < SMIN) begin
        pp_val = SMIN[2*B-1:0];
        pp_ovf = 1'b1;
      end
    end else begin
      pp_ovf = (wrap_ext != pp_sum);
    end
  end

  // Control FSM, counters, accumulators and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      ld_cnt    <= '0;
      col       <= '0;
      grp       <= '0;
      drn_cnt   <= '0;
      relu_q    <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      ovf       <= 1'b0;
      for (int l = 0; l < P; l++) acc[l] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          ld_cnt <= '0;
          if (loadMatrix) begin
            state <= S_LOAD_M;
          end else if (loadVector) begin
            state <= S_LOAD_V;
          end else if (start) begin
            state  <= S_COMPUTE;
            relu_q <= relu_en;
            col    <= '0;
            grp    <= '0;
          end
        end
        S_LOAD_M: begin
          ld_cnt <= ld_cnt + 1'b1;
          if (ld_cnt == LW'(K*K-1)) state <= S_IDLE;
        end
        S_LOAD_V: begin
          ld_cnt <= ld_cnt + 1'b1;
          if (ld_cnt == LW'(K-1)) state <= S_IDLE;
        end
        S_COMPUTE: begin
          for (int l = 0; l < P; l++) acc[l] <= acc_nxt[l];
          if (col == CW'(K-1)) begin
            col <= '0;
            if (grp == GW'(GN-1)) begin
              grp     <= '0;
              state   <= S_DRAIN;
              done    <= 1'b1;
              drn_cnt <= '0;
            end else begin
              grp <= grp + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drn_cnt == DW'(K)) begin
            out_valid <= 1'b0;
            drn_cnt   <= '0;
            state     <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
            data_out  <= pp_val;
            ovf       <= pp_ovf;
            drn_cnt   <= drn_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand and result storage; intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == S_LOAD_M) mat[ld_cnt] <= data_in;
      if (state == S_LOAD_V) vec[ld_cnt[CW-1:0]] <= data_in;
      if (state == S_COMPUTE && col == CW'(K-1)) begin
        for (int l = 0; l < P; l++) res[row_idx[l]] <= acc_nxt[l];
      end
    end
  end

endmodule

// File: doc/mvm_param.md
# mvm_param

Parametrised matrix-vector multiply engine that generalises the fixed 8×8, 8-bit, single-MAC engine to any square size K, element width B and P parallel MAC lanes. It adds output saturation, optional ReLU, an overflow flag and an explicit output-valid strobe. The bus protocol is kept: one-cycle load strobes, serial data entry and a one-cycle start strobe. Results come back as a done pulse followed by K serial result words. It sits beside the existing engines and is driven by the same serial load/start benches.

## Interface
- K, 8, matrix dimension (K×K matrix, K-element vector); K ≥ 2
- B, 8, signed element width of data_in
- P, 1, MAC lanes; K % P == 0
- SAT, 1, 1 = saturate results to 2B bits; 0 = wrap (keep low 2B bits)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- loadMatrix  in  1  one-cycle strobe; begins matrix load
- loadVector  in  1  one-cycle strobe; begins vector load
- start  in  1  one-cycle strobe; begins compute
- relu_en  in  1  sampled with start; clamps negative results to 0
- data_in  in  B  signed serial load data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of compute
- out_valid  out  1  high while data_out carries a result
- data_out  out  2B  signed result element
- ovf  out  1  qualified by out_valid; current element was saturated or wrapped

## Operation
- States: IDLE, LOAD_M, LOAD_V, COMPUTE, DRAIN.
- Strobes are accepted only in IDLE, with priority loadMatrix > loadVector > start. Strobes in any other state are ignored.
- LOAD_M: data_in is sampled on each of the K*K cycles after the strobe cycle, row-major (A[0][0], A[0][1], …), then the engine returns to IDLE.
- LOAD_V: data_in is sampled on each of the K cycles after the strobe cycle (x[0] first), then the engine returns to IDLE.
- Matrix and vector storage persist across operations. Reloading only one operand is legal. Storage is not cleared by reset; contents are undefined until loaded.
- COMPUTE: lanes handle rows in groups of P, one column per cycle, for K*K/P cycles total.
  - Product: B×B signed gives 2B bits.
  - Accumulator: 2B+clog2(K) bits, cleared at the start of each row group.
  - Finished rows are written to an internal K-entry result buffer.
- Post-processing per element, in order:
  - If relu_en and the sum is negative, the result is 0.
  - If SAT=1, clamp to [-2^(2B-1), 2^(2B-1)-1]. If SAT=0, take the low 2B bits.
  - ovf = 1 if the clamp or truncation changed the value.
- DRAIN: emits y[0]..y[K-1] on consecutive cycles with out_valid=1, then returns to IDLE.

## Timing
- Reset values: busy=0, done=0, out_valid=0, data_out=0, ovf=0, state=IDLE, all counters 0.
- Strobe in cycle t means the first data sample is in cycle t+1.
- start in cycle t:
  - COMPUTE covers cycles t+1..t+K*K/P.
  - done=1 in cycle t+K*K/P+1.
  - out_valid=1 and y[i] are presented in cycle t+K*K/P+2+i, for i = 0..K-1.
  - busy falls in cycle t+K*K/P+K+2; a new strobe is accepted in that cycle.
- data_out and ovf hold their last value when out_valid=0.
- Reset low in any state: all outputs take reset values at the next edge and any in-flight load, compute or drain is abandoned, so no done or out_valid follows. Partially loaded storage is undefined.
- Simultaneous loadMatrix and loadVector: only the matrix load starts; loadVector is dropped.

## Test plan
- Identity: K=8, P=1, identity matrix, x=1..8, start -> done 65 cycles after start; data_out = 1,2,…,8 on 8 consecutive out_valid cycles; ovf=0.
- Saturation: all A=-128, all x=-128 (sum 131072). SAT=1 -> every y=32767 with ovf=1. SAT=0 -> every y=0 with ovf=1.
- ReLU: all A=1, all x=-1. relu_en=1 -> all y=0, ovf=0. relu_en=0 -> all y=-8.
- Partial reload: load the identity matrix, then vector 1..8, compute; reload only the vector as 8..1, compute -> second result is 8,7,…,1.
- Busy rules:
  - loadMatrix and start pulsed during COMPUTE -> ignored; results unchanged.
  - reset low mid-COMPUTE -> busy=0 next cycle; no done or out_valid afterwards.
- Parallel lanes: K=8, P=4, random operands -> done 17 cycles after start; results match a golden model.
